// File: rtl/operand_frame_loader_pkg.sv
// operand_frame_loader_pkg: shared state encoding and default sizing for the operand frame loader
package operand_frame_loader_pkg;
  localparam int DATA_W_DEF  = 8;
  localparam int A_COUNT_DEF = 9;
  localparam int B_COUNT_DEF = 9;
  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_FULL   = 2'd2
  } state_t;
endpackage

// File: rtl/operand_frame_loader.sv
// operand_frame_loader: gathers a beat stream into operand arrays A and B and holds each frame for the multiplier
module operand_frame_loader
  import operand_frame_loader_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int A_COUNT = A_COUNT_DEF,
  parameter int B_COUNT = B_COUNT_DEF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic [DATA_W-1:0]                      in_data,
  input  logic                                   in_valid,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic [A_COUNT*DATA_W-1:0]              out_a,
  output logic [B_COUNT*DATA_W-1:0]              out_b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(A_COUNT+B_COUNT+1)-1:0]   fill,
  output logic                                   frame_err
);
  localparam int TOTAL  = A_COUNT + B_COUNT;
  localparam int FILL_W = $clog2(TOTAL + 1);
  localparam logic [FILL_W-1:0] A_LAST = FILL_W'(A_COUNT - 1);
  localparam logic [FILL_W-1:0] T_LAST = FILL_W'(TOTAL - 1);
  localparam logic [FILL_W-1:0] A_N    = FILL_W'(A_COUNT);
  localparam logic [FILL_W-1:0] ONE    = FILL_W'(1);
  state_t state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic err_q, err_d, armed_q, armed_d;
  logic [A_COUNT*DATA_W-1:0] a_q, a_d;
  logic [B_COUNT*DATA_W-1:0] b_q, b_d;
  logic acc, last_beat, early;
  // state register; armed_q keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= ST_LOAD_A;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  // next state: clear wins, an early last discards the frame, the final beat moves to FULL
  always_comb begin
    state_d = state_q;
    armed_d = 1'b1;
    if (clear) state_d = ST_LOAD_A;
    else
      case (state_q)
        ST_LOAD_A: if (acc) state_d = (!early && fill_q == A_LAST) ? ST_LOAD_B : ST_LOAD_A;
        ST_LOAD_B: if (acc) state_d = early ? ST_LOAD_A : (last_beat ? ST_FULL : ST_LOAD_B);
        ST_FULL:   if (out_ready) state_d = ST_LOAD_A;
        default:   state_d = ST_LOAD_A;
      endcase
  end
  // handshake outputs are decoded from registered state only
  always_comb begin
    in_ready  = armed_q && state_q != ST_FULL;
    out_valid = state_q == ST_FULL;
  end
  // beat counter, sticky length error and element write decode
  always_comb begin
    acc       = in_valid && in_ready;
    last_beat = fill_q == T_LAST;
    early     = in_last && !last_beat;
    fill_d    = clear ? '0 : (out_valid && out_ready) ? '0 : acc ? (early ? '0 : fill_q + ONE) : fill_q;
    err_d     = !clear && (err_q || (acc && (early || (last_beat && !in_last))));
    a_d       = a_q;
    b_d       = b_q;
    if (acc && !clear) begin
      if (fill_q < A_N) a_d[int'(fill_q)*DATA_W +: DATA_W] = in_data;
      else b_d[int'(fill_q - A_N)*DATA_W +: DATA_W] = in_data;
    end
  end
  // datapath registers; storage is only zeroed by reset, frames overwrite it in place
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fill_q <= '0;
      err_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      fill_q <= fill_d;
      err_q  <= err_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign fill      = fill_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_operand_frame_loader.sv
// tb_operand_frame_loader: scoreboard bench with a queue-based frame model for operand_frame_loader
module tb_operand_frame_loader;
  localparam int AC  = 9;
  localparam int BC  = 9;
  localparam int TOT = AC + BC;
  logic clk = 1'b0, reset = 1'b0, clear = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, out_valid, frame_err;
  logic [AC*8-1:0] out_a;
  logic [BC*8-1:0] out_b;
  logic [4:0] fill;
  typedef struct {
    logic [AC*8-1:0] a;
    logic [BC*8-1:0] b;
    logic            err;
  } exp_t;
  exp_t exp_q[$];
  logic [7:0] cur[$];
  logic err_m = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [AC*8-1:0] hold;

  always #5 clk = ~clk;

  operand_frame_loader dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .out_ready(out_ready),
    .fill(fill), .frame_err(frame_err)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] d, input logic l);
    cur.push_back(d);
    if (l && cur.size() < TOT) begin
      cur.delete();
      err_m = 1'b1;
    end else if (cur.size() == TOT) begin
      exp_t e;
      if (!l) err_m = 1'b1;
      for (int i = 0; i < AC; i++) e.a[i*8 +: 8] = cur[i];
      for (int i = 0; i < BC; i++) e.b[i*8 +: 8] = cur[AC+i];
      e.err = err_m;
      exp_q.push_back(e);
      cur.delete();
    end
  endtask

  task automatic model_flush();
    cur.delete();
    exp_q.delete();
    err_m = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    logic r;
    logic done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        model_accept(d, l);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_timeout: beat %0h not accepted within 50 cycles", d);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int n, input int last_k, input bit gaps, input bit rnd);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
      send_beat(rnd ? 8'($urandom) : 8'(int'(base) + k), k == last_k);
    end
  endtask

  task automatic accept_frame(input int dly);
    int t;
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
    end else begin
      repeat (dly) begin
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_flush();
  endtask

  // monitor: status checked every cycle, frame contents popped on each output handshake
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("fill", fill, exp_q.size() != 0 ? TOT : cur.size());
      chk("frame_err", frame_err, err_m);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL handshake: frame presented got out_valid=1 required no frame pending");
        end else begin
          e = exp_q.pop_front();
          chk("frame_a", out_a, e.a);
          chk("frame_b", out_b, e.b);
          chk("frame_err_at_out", frame_err, e.err);
        end
      end
    end
  end

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fill", fill, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    #21 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", in_ready, 1);
    // frame 0x01..0x12 back to back, consumer stalled
    send_frame(8'h01, TOT, TOT - 1, 0, 0);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_a0", out_a[7:0], 8'h01);
    chk("t1_a8", out_a[71:64], 8'h09);
    chk("t1_b0", out_b[7:0], 8'h0A);
    chk("t1_b8", out_b[71:64], 8'h12);
    chk("t1_fill", fill, TOT);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_frame_err", frame_err, 0);
    @(posedge clk);
    #1;
    // backpressure while full, then release and reload
    hold = out_a;
    in_valid = 1'b1;
    in_data  = 8'hA0;
    repeat (5) begin
      @(negedge clk);
      chk("t2_in_ready_full", in_ready, 0);
    end
    chk("t2_held_a", out_a, hold);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("t2_rearm_in_ready", in_ready, 1);
    send_frame(8'hA0, TOT, TOT - 1, 0, 0);
    accept_frame(2);
    // early last discards the frame
    send_frame(8'h30, 5, 4, 0, 0);
    @(negedge clk);
    chk("t3_early_err", frame_err, 1);
    chk("t3_early_fill", fill, 0);
    @(posedge clk);
    #1;
    send_frame(8'h40, TOT, TOT - 1, 0, 0);
    accept_frame(0);
    // missing last completes the frame with an error, then clear
    do_clear();
    send_frame(8'h50, TOT, -1, 0, 0);
    @(negedge clk);
    chk("t4_out_valid", out_valid, 1);
    chk("t4_missing_err", frame_err, 1);
    @(posedge clk);
    #1;
    do_clear();
    @(negedge clk);
    chk("t4_clr_valid", out_valid, 0);
    chk("t4_clr_err", frame_err, 0);
    chk("t4_clr_fill", fill, 0);
    @(posedge clk);
    #1;
    // gapped loading, clear coinciding with beat 10
    send_frame(8'h60, 10, -1, 1, 0);
    in_valid = 1'b1;
    in_data  = 8'h6A;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    model_flush();
    @(negedge clk);
    chk("t5_clear_fill", fill, 0);
    @(posedge clk);
    #1;
    send_frame(8'h00, TOT, TOT - 1, 1, 1);
    accept_frame($urandom_range(0, 3));
    // asynchronous reset in the middle of a frame
    send_frame(8'h70, 12, -1, 1, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_flush();
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_fill", fill, 0);
    chk("t6_out_a", out_a, 0);
    chk("t6_out_b", out_b, 0);
    chk("t6_in_ready", in_ready, 0);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'h80, TOT, TOT - 1, 0, 0);
    accept_frame(1);
    // random frames with occasional length errors
    for (int f = 0; f < 8; f++) begin
      bit early;
      int lk;
      early = $urandom_range(0, 4) == 0;
      lk = early ? int'($urandom_range(0, TOT - 2)) : ($urandom_range(0, 5) == 0 ? -1 : TOT - 1);
      send_frame(8'h00, early ? lk + 1 : TOT, lk, 1, 1);
      if (!early) accept_frame($urandom_range(0, 4));
    end
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
